// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Fetch/decode pipeline controller. It decides when the instruction register
// advances, squashes the fetch slot after a taken branch, and sequences entry
// into an interrupt handler. Three states:
//   RUN     - normal issue; advances whenever fetch data is valid and the data
//             memory is not stalling.
//   STALL   - entered after any RUN cycle that could not advance; the PC is
//             held until the pipeline can advance again.
//   IRQ_ENT - interrupt-entry bubble of IRQ_LAT cycles (3-bit down-counter).
//
// Optional feature macro: PIPE_CTRL_IRQ_EN
//   defined   : interrupt entry, nesting block and return-from-interrupt
//   undefined : no interrupt logic; i_irq_req / i_reti are ignored and
//               o_in_irq / o_irq_ack are tied low.
//
// The NOP encoding loaded on annul / IRQ entry / reset comes from the
// CPU_NOP_INSN macro (a default is supplied below if the build does not set it).
//
// Parameters
//   W_INSN  - instruction width
//   IRQ_LAT - IRQ-entry bubble cycles, legal range 1..7
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst        synchronous active-low reset
//   i_insn       fetched instruction word
//   i_mem_rdy    fetch data valid this cycle
//   i_dmem_busy  data-memory stall request
//   i_br_taken   execute stage resolves a taken branch
//   i_irq_req    level interrupt request
//   i_reti       return-from-interrupt in execute
//   o_insn_ce    pipeline advance enable (combinational)
//   o_insn_q     registered instruction to decode
//   o_annul      current fetch is being squashed (combinational)
//   o_pc_sel     00 sequential, 01 branch target, 10 IRQ vector, 11 hold
//   o_in_irq     handler active
//   o_irq_ack    one-cycle interrupt acknowledge
// -----------------------------------------------------------------------------

`ifndef CPU_NOP_INSN
`define CPU_NOP_INSN 16'h4E71
`endif

module pipe_ctrl #(
    parameter int W_INSN  = 16,
    parameter int IRQ_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [W_INSN-1:0] i_insn,
    input  logic              i_mem_rdy,
    input  logic              i_dmem_busy,
    input  logic              i_br_taken,
    input  logic              i_irq_req,
    input  logic              i_reti,
    output logic              o_insn_ce,
    output logic [W_INSN-1:0] o_insn_q,
    output logic              o_annul,
    output logic [1:0]        o_pc_sel,
    output logic              o_in_irq,
    output logic              o_irq_ack
);

    localparam logic [W_INSN-1:0] NOP_INSN = W_INSN'(`CPU_NOP_INSN);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_STALL   = 2'b01,
        ST_IRQ_ENT = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              pend_annul_r;
    logic              pend_annul_nxt_s;
    logic [W_INSN-1:0] insn_nxt_s;
    logic              adv_s;
    logic              load_nop_s;

    // Interrupt-sequencing hooks; constant in builds without interrupt support.
    logic              irq_take_s;
    logic              irq_first_s;
    logic              irq_last_s;

    // Raw advance condition shared by RUN and STALL.
    assign adv_s = i_mem_rdy & ~i_dmem_busy;

    // Squash whenever the pipeline advances over a slot fetched down the wrong
    // path: either the branch resolves now or it resolved during a stall.
    assign o_annul = (i_br_taken | pend_annul_r) & o_insn_ce;

    // Next-state, advance enable and PC-select decode.
    always_comb begin
        state_nxt_s = state_r;
        o_insn_ce   = 1'b0;
        o_pc_sel    = 2'b00;
        case (state_r)
            ST_RUN: begin
                o_insn_ce = adv_s;
                if (i_br_taken) begin
                    o_pc_sel = 2'b01;
                end else begin
                    o_pc_sel = 2'b00;
                end
                if (!adv_s) begin
                    state_nxt_s = ST_STALL;
                end else if (irq_take_s) begin
                    state_nxt_s = ST_IRQ_ENT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STALL: begin
                o_insn_ce = adv_s;
                o_pc_sel  = 2'b11;
                if (adv_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STALL;
                end
            end
            ST_IRQ_ENT: begin
                // The bubble length is fixed: data-memory stalls are ignored
                // here and only take effect once back in RUN.
                o_insn_ce = 1'b0;
                if (irq_first_s) begin
                    o_pc_sel = 2'b10;
                end else begin
                    o_pc_sel = 2'b11;
                end
                if (irq_last_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IRQ_ENT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                o_insn_ce   = 1'b0;
                o_pc_sel    = 2'b11;
            end
        endcase
    end

    // Pending-annul bookkeeping: a branch seen while frozen is remembered
    // until the next advance, which then squashes exactly one slot.
    always_comb begin
        pend_annul_nxt_s = pend_annul_r;
        if (o_insn_ce) begin
            pend_annul_nxt_s = 1'b0;
        end else if (i_br_taken) begin
            pend_annul_nxt_s = 1'b1;
        end else begin
            pend_annul_nxt_s = pend_annul_r;
        end
    end

    // Instruction register input select: hold, NOP, or the fetched word.
    always_comb begin
        load_nop_s = o_annul | irq_take_s;
        insn_nxt_s = o_insn_q;
        if (!o_insn_ce) begin
            insn_nxt_s = o_insn_q;
        end else if (load_nop_s) begin
            insn_nxt_s = NOP_INSN;
        end else begin
            insn_nxt_s = i_insn;
        end
    end

    // Core state, pending-annul flag and instruction register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r      <= ST_RUN;
            pend_annul_r <= 1'b0;
            o_insn_q     <= NOP_INSN;
        end else begin
            state_r      <= state_nxt_s;
            pend_annul_r <= pend_annul_nxt_s;
            o_insn_q     <= insn_nxt_s;
        end
    end

`ifdef PIPE_CTRL_IRQ_EN
    localparam logic [2:0] IRQ_LAT_C = 3'(IRQ_LAT);

    logic [2:0] irq_cnt_r;
    logic [2:0] irq_cnt_nxt_s;
    logic       in_irq_r;
    logic       in_irq_nxt_s;
    logic       irq_ack_r;
    logic       irq_ack_nxt_s;

    // Entry only from an advancing RUN cycle that is not itself being
    // squashed; a branch wins and the request is re-evaluated later.
    assign irq_take_s  = (state_r == ST_RUN) & adv_s & i_irq_req & ~in_irq_r
                         & ~i_br_taken & ~pend_annul_r;
    assign irq_first_s = (irq_cnt_r == IRQ_LAT_C);
    assign irq_last_s  = (irq_cnt_r <= 3'd1);

    // Bubble counter, handler flag and acknowledge next-state.
    // Ack and handler flag are registered out of the final bubble cycle, so a
    // reset landing inside the bubble aborts entry without any acknowledge.
    always_comb begin
        irq_cnt_nxt_s = irq_cnt_r;
        in_irq_nxt_s  = in_irq_r;
        irq_ack_nxt_s = 1'b0;
        if (irq_take_s) begin
            irq_cnt_nxt_s = IRQ_LAT_C;
        end else if (state_r == ST_IRQ_ENT) begin
            if (irq_last_s) begin
                irq_cnt_nxt_s = 3'd0;
                irq_ack_nxt_s = 1'b1;
                in_irq_nxt_s  = 1'b1;
            end else begin
                irq_cnt_nxt_s = irq_cnt_r - 3'd1;
            end
        end else if (o_insn_ce && i_reti) begin
            in_irq_nxt_s = 1'b0;
        end else begin
            in_irq_nxt_s = in_irq_r;
        end
    end

    // Interrupt sequencing registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            irq_cnt_r <= 3'd0;
            in_irq_r  <= 1'b0;
            irq_ack_r <= 1'b0;
        end else begin
            irq_cnt_r <= irq_cnt_nxt_s;
            in_irq_r  <= in_irq_nxt_s;
            irq_ack_r <= irq_ack_nxt_s;
        end
    end

    assign o_in_irq  = in_irq_r;
    assign o_irq_ack = irq_ack_r;
`else
    // Interrupt inputs are intentionally ignored in this build.
    logic unused_irq_s;
    assign unused_irq_s = i_irq_req | i_reti;

    assign irq_take_s  = 1'b0;
    assign irq_first_s = 1'b1;
    assign irq_last_s  = 1'b1;
    assign o_in_irq    = 1'b0;
    assign o_irq_ack   = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: one record per clock cycle holding the
// inputs driven in that cycle and the outputs expected in that same cycle.
`ifndef CPU_NOP_INSN
`define CPU_NOP_INSN 16'h4E71
`endif

module tb_pipe_ctrl;

    localparam logic [15:0] NOP = `CPU_NOP_INSN;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] insn;
        logic        rdy;
        logic        busy;
        logic        br;
        logic        irq;
        logic        reti;
        logic        ce;
        logic        annul;
        logic [1:0]  pc;
        logic [15:0] q;
        logic        in_irq;
        logic        ack;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] insn;
    logic        mem_rdy;
    logic        dmem_busy;
    logic        br_taken;
    logic        irq_req;
    logic        reti;
    logic        insn_ce;
    logic [15:0] insn_q;
    logic        annul;
    logic [1:0]  pc_sel;
    logic        in_irq;
    logic        irq_ack;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pipe_ctrl #(.W_INSN(16), .IRQ_LAT(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_insn      (insn),
        .i_mem_rdy   (mem_rdy),
        .i_dmem_busy (dmem_busy),
        .i_br_taken  (br_taken),
        .i_irq_req   (irq_req),
        .i_reti      (reti),
        .o_insn_ce   (insn_ce),
        .o_insn_q    (insn_q),
        .o_annul     (annul),
        .o_pc_sel    (pc_sel),
        .o_in_irq    (in_irq),
        .o_irq_ack   (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic r, logic [15:0] i, logic rd, logic bz,
                                logic b, logic ir, logic rt, logic ce, logic an,
                                logic [1:0] pc, logic [15:0] q, logic ii, logic ak);
        vec_t v;
        v.name = n; v.rst = r; v.insn = i; v.rdy = rd; v.busy = bz; v.br = b;
        v.irq = ir; v.reti = rt; v.ce = ce; v.annul = an; v.pc = pc; v.q = q;
        v.in_irq = ii; v.ack = ak;
        return v;
    endfunction

    task automatic chk(string n, string f, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
        end
    endtask

    // Drive one cycle of stimulus after the edge, compare on the falling edge.
    task automatic run_vec(vec_t v);
        vec_t e;
        @(posedge clk);
        #2;
        rst       = v.rst;
        insn      = v.insn;
        mem_rdy   = v.rdy;
        dmem_busy = v.busy;
        br_taken  = v.br;
        irq_req   = v.irq;
        reti      = v.reti;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk(e.name, "ce",     {15'd0, insn_ce}, {15'd0, e.ce});
        chk(e.name, "annul",  {15'd0, annul},   {15'd0, e.annul});
        chk(e.name, "pc_sel", {14'd0, pc_sel},  {14'd0, e.pc});
        chk(e.name, "insn_q", insn_q,           e.q);
        chk(e.name, "in_irq", {15'd0, in_irq},  {15'd0, e.in_irq});
        chk(e.name, "ack",    {15'd0, irq_ack}, {15'd0, e.ack});
    endtask

    initial begin
        rst = 1'b0; insn = 16'h0000; mem_rdy = 1'b0; dmem_busy = 1'b0;
        br_taken = 1'b0; irq_req = 1'b0; reti = 1'b0;

        //                  name      rst  insn     rdy  bsy  br   irq  rti  | ce   an   pc     q        in   ack
        tbl.push_back(mk("rst0",    1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00,NOP,     1'b0,1'b0));
        tbl.push_back(mk("rst1",    1'b0,16'h1234,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,NOP,     1'b0,1'b0));
        tbl.push_back(mk("rel0",    1'b1,16'h1234,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,NOP,     1'b0,1'b0));
        tbl.push_back(mk("seq1",    1'b1,16'h5678,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,16'h1234,1'b0,1'b0));
        tbl.push_back(mk("br_ce",   1'b1,16'hABCD,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,2'b01,16'h5678,1'b0,1'b0));
        tbl.push_back(mk("br_nop",  1'b1,16'h1111,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,NOP,     1'b0,1'b0));
        tbl.push_back(mk("seq2",    1'b1,16'h2222,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,16'h1111,1'b0,1'b0));
        tbl.push_back(mk("brst0",   1'b1,16'h3333,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,2'b01,16'h2222,1'b0,1'b0));
        tbl.push_back(mk("brst1",   1'b1,16'h3333,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,16'h2222,1'b0,1'b0));
        tbl.push_back(mk("brst2",   1'b1,16'h3333,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,16'h2222,1'b0,1'b0));
        tbl.push_back(mk("pend_an", 1'b1,16'h4444,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,2'b11,16'h2222,1'b0,1'b0));
        tbl.push_back(mk("pend_nop",1'b1,16'h5555,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,NOP,     1'b0,1'b0));
        tbl.push_back(mk("rdy_lo",  1'b1,16'h6666,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00,16'h5555,1'b0,1'b0));
        tbl.push_back(mk("stall",   1'b1,16'h6666,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,16'h5555,1'b0,1'b0));
        tbl.push_back(mk("st_exit", 1'b1,16'h7777,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b11,16'h5555,1'b0,1'b0));
        tbl.push_back(mk("run_a",   1'b1,16'h8888,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,16'h7777,1'b0,1'b0));
        tbl.push_back(mk("run_b",   1'b1,16'h9999,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,16'h8888,1'b0,1'b0));
        tbl.push_back(mk("rdy_lo2", 1'b1,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00,16'h9999,1'b0,1'b0));
        tbl.push_back(mk("st_rst",  1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,16'h9999,1'b0,1'b0));
        tbl.push_back(mk("post_rst",1'b1,16'hAAAA,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,NOP,     1'b0,1'b0));
        tbl.push_back(mk("run_c",   1'b1,16'hBBBB,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,16'hAAAA,1'b0,1'b0));

        foreach (tbl[k]) run_vec(tbl[k]);

`ifdef PIPE_CTRL_IRQ_EN
        // Entry, fixed bubble despite busy, ack, nesting block, reti.
        run_vec(mk("irq_take", 1'b1,16'hC001,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,2'b00,16'hBBBB,1'b0,1'b0));
        run_vec(mk("irq_e1",   1'b1,16'hC002,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,2'b10,NOP,     1'b0,1'b0));
        run_vec(mk("irq_e2",   1'b1,16'hC003,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,2'b11,NOP,     1'b0,1'b0));
        run_vec(mk("irq_ack",  1'b1,16'hC004,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,2'b00,NOP,     1'b1,1'b1));
        run_vec(mk("no_nest",  1'b1,16'hC005,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,2'b00,16'hC004,1'b1,1'b0));
        run_vec(mk("reti_irq", 1'b1,16'hC006,1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,2'b00,16'hC005,1'b1,1'b0));
        run_vec(mk("reenter",  1'b1,16'hC007,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,2'b00,16'hC006,1'b0,1'b0));
        run_vec(mk("re_e1",    1'b1,16'hC008,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b10,NOP,     1'b0,1'b0));
        run_vec(mk("re_e2",    1'b1,16'hC009,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,NOP,     1'b0,1'b0));
        run_vec(mk("re_ack",   1'b1,16'hC00A,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,2'b00,NOP,     1'b1,1'b1));
        // Branch and IRQ together: branch wins, entry on the next advance.
        run_vec(mk("br_irq",   1'b1,16'hC00B,1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1,2'b01,16'hC00A,1'b0,1'b0));
        run_vec(mk("irq_late", 1'b1,16'hC00C,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,2'b00,NOP,     1'b0,1'b0));
        run_vec(mk("late_e1",  1'b1,16'hC00D,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b10,NOP,     1'b0,1'b0));
        // Reset during the second bubble cycle aborts without acknowledge.
        run_vec(mk("late_rst", 1'b0,16'hC00E,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,NOP,     1'b0,1'b0));
        run_vec(mk("abort",    1'b1,16'hD000,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,NOP,     1'b0,1'b0));
        run_vec(mk("abort2",   1'b1,16'hD001,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,16'hD000,1'b0,1'b0));
`else
        // Interrupt inputs have no effect in this build.
        run_vec(mk("irq_ign",  1'b1,16'hC001,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,2'b00,16'hBBBB,1'b0,1'b0));
        run_vec(mk("reti_ign", 1'b1,16'hC002,1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,2'b00,16'hC001,1'b0,1'b0));
        run_vec(mk("irq_ign2", 1'b1,16'hC003,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,2'b00,16'hC002,1'b0,1'b0));
        run_vec(mk("irq_ign3", 1'b1,16'hC004,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b00,16'hC003,1'b0,1'b0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter W_INSN, default 16: instruction width.
REQ-002 SHALL have parameter IRQ_LAT, default 2: IRQ-entry bubble cycles, legal range 1..7.
REQ-003 SHALL have port i_clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port i_insn, input, W_INSN: fetched instruction word.
REQ-006 SHALL have port i_mem_rdy, input, 1: fetch data valid this cycle.
REQ-007 SHALL have port i_dmem_busy, input, 1: data-memory stall request.
REQ-008 SHALL have port i_br_taken, input, 1: execute stage resolves a taken branch.
REQ-009 SHALL have port i_irq_req, input, 1: level interrupt request.
REQ-010 SHALL have port i_reti, input, 1: return-from-interrupt in execute.
REQ-011 SHALL have port o_insn_ce, output, 1: pipeline advance enable.
REQ-012 SHALL have port o_insn_q, output, W_INSN: registered instruction to decode.
REQ-013 SHALL have port o_annul, output, 1: current fetch is being squashed.
REQ-014 SHALL have port o_pc_sel, output, 2: 00 sequential, 01 branch target, 10 IRQ vector, 11 hold.
REQ-015 SHALL have port o_in_irq, output, 1: handler active.
REQ-016 SHALL have port o_irq_ack, output, 1: one-cycle acknowledge.

Function
REQ-017 SHALL implement FSM states RUN, STALL, IRQ_ENT.
REQ-018 RUN: o_insn_ce = i_mem_rdy & ~i_dmem_busy; when this is 0, next state SHALL be STALL; STALL returns to RUN on the first cycle it is 1.
REQ-019 On o_insn_ce=1 with no annul, o_insn_q SHALL load i_insn at the edge; with o_insn_ce=0 it SHALL hold.
REQ-020 o_annul SHALL be combinational (i_br_taken | pend_annul) & o_insn_ce; when o_annul=1, o_insn_q SHALL load `CPU_NOP_INSN, not i_insn.
REQ-021 i_br_taken while o_insn_ce=0 SHALL set pend_annul; it clears on the next o_insn_ce=1 cycle, which annuls exactly one instruction.
REQ-022 o_pc_sel SHALL be 01 when i_br_taken=1 in RUN, 10 during the first IRQ_ENT cycle, 11 in STALL and the remaining IRQ_ENT cycles, and 00 otherwise.
REQ-023 IRQ entry SHALL occur from RUN when i_irq_req=1, o_in_irq=0, o_insn_ce=1, and there is no branch or pending annul; in that cycle o_insn_q SHALL load NOP.
REQ-024 Branch and IRQ in the same cycle: the branch SHALL win and the IRQ is re-evaluated at the next o_insn_ce=1.
REQ-025 IRQ_ENT SHALL last exactly IRQ_LAT cycles with o_insn_ce=0, using a 3-bit down-counter.
- o_irq_ack=1 and o_in_irq set on the last IRQ_ENT cycle, then RUN.
REQ-026 Nested entry SHALL be blocked while o_in_irq=1.
- i_reti with o_insn_ce=1 clears o_in_irq at the edge.
- i_reti & i_irq_req together: re-entry no earlier than the following ce cycle.
REQ-027 i_dmem_busy during IRQ_ENT SHALL NOT extend or shorten IRQ_ENT; the STALL check applies after the return to RUN.

Reset
REQ-028 While i_rst=0 at an edge, the block SHALL set: state RUN, o_insn_q=`CPU_NOP_INSN, pend_annul=0, o_in_irq=0, o_irq_ack=0, counter=0.
REQ-029 Reset mid-IRQ_ENT or mid-STALL SHALL abort the sequence with no ack.

Configuration
REQ-030 The macro PIPE_CTRL_IRQ_EN SHALL control IRQ support.
- Defined: REQ-023..026 apply.
- Undefined: IRQ_ENT logic is removed, i_irq_req and i_reti are ignored, and o_in_irq and o_irq_ack are tied to 0.

Verification
REQ-031 Reset release, i_mem_rdy=1, i_insn=16'h1234 -> o_insn_q=16'h1234 one cycle later, o_pc_sel=00.
REQ-032 i_br_taken=1 with ce=1, i_insn=16'hABCD -> o_annul=1, o_pc_sel=01, next cycle o_insn_q=`CPU_NOP_INSN.
REQ-033 i_br_taken=1 while i_dmem_busy=1 for 3 cycles -> o_insn_q held; first ce cycle after the stall loads NOP; the next ce loads i_insn.
REQ-034 i_irq_req=1 with IRQ_LAT=2 -> o_insn_q=NOP, o_pc_sel 10 then 11, o_insn_ce=0 for 2 cycles, o_irq_ack pulse on cycle 2, o_in_irq=1; i_reti later -> o_in_irq=0.
REQ-035 i_irq_req and i_br_taken in the same cycle -> annul first, IRQ entry begins at the next ce cycle.
REQ-036 i_rst=0 during the second IRQ_ENT cycle -> no o_irq_ack, o_in_irq=0, o_insn_q=NOP.
